// File: rtl/vram_write_scheduler.sv
// Arbitrates the single VRAM write port between a full-screen clear engine and
// a touch painter that stamps a BRUSH_SIZE x BRUSH_SIZE square per accepted touch.
module vram_write_scheduler #(
  parameter int          DISPLAY_WIDTH  = 240,
  parameter int          DISPLAY_HEIGHT = 320,
  parameter int          VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int          BRUSH_SIZE     = 3,
  parameter logic [15:0] CLEAR_COLOR    = 16'h0000,
  parameter logic [15:0] PAINT_COLOR    = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_req,
  input  logic                      touch_valid,
  input  logic [8:0]                touch_x,
  input  logic [8:0]                touch_y,
  output logic                      vram_wr_ena,
  output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
  output logic [15:0]               vram_wr_data,
  output logic                      busy,
  output logic                      clearing
);

  localparam int AW = $clog2(VRAM_L);
  localparam int BW = (BRUSH_SIZE > 1) ? $clog2(BRUSH_SIZE) : 1;
  localparam logic [9:0]    W10       = 10'(DISPLAY_WIDTH);
  localparam logic [9:0]    H10       = 10'(DISPLAY_HEIGHT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_L - 1);
  localparam logic [AW-1:0] W_AW      = AW'(DISPLAY_WIDTH);
  localparam logic [BW-1:0] B_LAST    = BW'(BRUSH_SIZE - 1);

  typedef enum logic [1:0] {
    S_CLEARING = 2'd0,
    S_IDLE     = 2'd1,
    S_PAINT    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [8:0]      x0_q, x0_d;
  logic [8:0]      y0_q, y0_d;
  logic [BW-1:0]   i_q, i_d;
  logic [BW-1:0]   j_q, j_d;
  logic            wr_ena_q, wr_ena_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;

  logic [9:0]      px_s;
  logic [9:0]      py_s;
  logic            pix_in_range_s;
  logic [AW-1:0]   pix_addr_s;
  logic            touch_ok_s;

  // 10-bit sums keep the bound check exact even at the far display edge
  assign px_s           = {1'b0, x0_q} + 10'(i_q);
  assign py_s           = {1'b0, y0_q} + 10'(j_q);
  assign pix_in_range_s = (px_s < W10) && (py_s < H10);
  assign pix_addr_s     = AW'(py_s) * W_AW + AW'(px_s);
  assign touch_ok_s     = touch_valid && ({1'b0, touch_x} < W10) && ({1'b0, touch_y} < H10);

  // Next-state and registered write-port values
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    i_d       = i_q;
    j_d       = j_q;
    wr_ena_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_CLEARING: begin
        wr_ena_d  = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = CLEAR_COLOR;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      S_IDLE: begin
        if (clear_req) begin
          state_d   = S_CLEARING;
          clr_cnt_d = '0;
        end else if (touch_ok_s) begin
          state_d = S_PAINT;
          x0_d    = touch_x;
          y0_d    = touch_y;
          i_d     = '0;
          j_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PAINT: begin
        if (clear_req) begin
          state_d   = S_CLEARING;
          clr_cnt_d = '0;
        end else begin
          // Clipped slots still consume an edge; nothing wraps onto the next row
          if (pix_in_range_s) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = pix_addr_s;
            wr_data_d = PAINT_COLOR;
          end else begin
            wr_ena_d  = 1'b0;
          end
          if (i_q == B_LAST) begin
            i_d = '0;
            if (j_q == B_LAST) begin
              state_d = S_IDLE;
            end else begin
              j_d = j_q + BW'(1);
            end
          end else begin
            i_d = i_q + BW'(1);
          end
        end
      end
      default: begin
        state_d   = S_CLEARING;
        clr_cnt_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset into a fresh clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEARING;
      clr_cnt_q <= '0;
      x0_q      <= 9'd0;
      y0_q      <= 9'd0;
      i_q       <= '0;
      j_q       <= '0;
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      i_q       <= i_d;
      j_q       <= j_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign vram_wr_ena  = wr_ena_q;
  assign vram_wr_addr = wr_addr_q;
  assign vram_wr_data = wr_data_q;
  assign busy         = (state_q != S_IDLE);
  assign clearing     = (state_q == S_CLEARING);

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Scoreboard bench: a full-size instance for the power-on clear and painting, and
// a small-display instance for aborts, priority, reset restarts and random traffic.
module tb_vram_write_scheduler;

  localparam int WA = 240, HA = 320, BA = 2, LA = WA * HA;
  localparam int WB = 8,   HB = 6,   BB = 3, LB = WB * HB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, clr_a, tv_a, ena_a, busy_a, clearing_a;
  logic [8:0]  x_a, y_a;
  logic [16:0] addr_a;
  logic [15:0] data_a;
  logic        rst_b, clr_b, tv_b, ena_b, busy_b, clearing_b;
  logic [8:0]  x_b, y_b;
  logic [5:0]  addr_b;
  logic [15:0] data_b;

  vram_write_scheduler #(.DISPLAY_WIDTH(WA), .DISPLAY_HEIGHT(HA), .BRUSH_SIZE(BA)) dut_a (
    .clk(clk), .rst(rst_a), .clear_req(clr_a), .touch_valid(tv_a),
    .touch_x(x_a), .touch_y(y_a), .vram_wr_ena(ena_a), .vram_wr_addr(addr_a),
    .vram_wr_data(data_a), .busy(busy_a), .clearing(clearing_a));

  vram_write_scheduler #(.DISPLAY_WIDTH(WB), .DISPLAY_HEIGHT(HB), .BRUSH_SIZE(BB)) dut_b (
    .clk(clk), .rst(rst_b), .clear_req(clr_b), .touch_valid(tv_b),
    .touch_x(x_b), .touch_y(y_b), .vram_wr_ena(ena_b), .vram_wr_addr(addr_b),
    .vram_wr_data(data_b), .busy(busy_b), .clearing(clearing_b));

  typedef struct packed { int cyc; int addr; int data; } exp_t;
  typedef struct packed { int act; int expv; } dchk_t;

  exp_t  qa[$];
  exp_t  qb[$];
  dchk_t dq[$];
  string dn[$];

  int ecnt = 0;
  int tests = 0;
  int fails = 0;
  int wr_cnt [2]    = '{0, 0};
  int busy_cnt [2]  = '{0, 0};
  bit en [2]        = '{1'b0, 1'b0};
  int idle_from [2] = '{0, 0};
  int trig [2]      = '{-1000000, -1000000};
  int paint_last [2] = '{-1, -1};

  function automatic int dim_w(int d); return (d == 0) ? WA : WB; endfunction
  function automatic int dim_h(int d); return (d == 0) ? HA : HB; endfunction
  function automatic int dim_b(int d); return (d == 0) ? BA : BB; endfunction
  function automatic int qsize(int d); return (d == 0) ? qa.size() : qb.size(); endfunction
  function automatic exp_t qfront(int d); return (d == 0) ? qa[0] : qb[0]; endfunction
  function automatic exp_t qpop(int d);
    return (d == 0) ? qa.pop_front() : qb.pop_front();
  endfunction

  task automatic push(int d, int c, int a, int v);
    exp_t e;
    e.cyc = c; e.addr = a; e.data = v;
    if (d == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  // Drop every predicted write from edge n onward (reset or abort cancels them)
  task automatic flush_from(int d, int n);
    if (d == 0) begin
      while (qa.size() > 0 && qa[$].cyc >= n) void'(qa.pop_back());
    end else begin
      while (qb.size() > 0 && qb[$].cyc >= n) void'(qb.pop_back());
    end
  endtask

  task automatic start_clear(int d, int n);
    int l = dim_w(d) * dim_h(d);
    flush_from(d, n);
    for (int k = 0; k < l; k++) push(d, n + 1 + k, k, 0);
    trig[d] = n;
    idle_from[d] = n + l + 1;
    paint_last[d] = -1;
  endtask

  // Reference: what the inputs sampled at edge n cause, in terms of future writes
  task automatic model_edge(int d, int n, bit r, bit c, bit t, int x, int y);
    int b = dim_b(d);
    if (r) begin
      en[d] = 1'b1;
      start_clear(d, n);
    end else if (en[d]) begin
      if (n < idle_from[d]) begin
        if (n <= paint_last[d] && c) start_clear(d, n);
      end else if (c) begin
        start_clear(d, n);
      end else if (t && x < dim_w(d) && y < dim_h(d)) begin
        for (int k = 0; k < b * b; k++) begin
          int px = x + k % b;
          int py = y + k / b;
          if (px < dim_w(d) && py < dim_h(d)) push(d, n + 1 + k, py * dim_w(d) + px, 16'hFFFF);
        end
        paint_last[d] = n + b * b;
        idle_from[d] = n + b * b + 1;
      end
    end
  endtask

  task automatic check_out(int d, int n, logic ena, int addr, int data, logic bsy, logic clr);
    exp_t e;
    bit have;
    bit exp_busy;
    bit exp_clr;
    int l = dim_w(d) * dim_h(d);
    e = '0;
    have = 1'b0;
    if (!en[d]) return;
    exp_busy = (n + 1 < idle_from[d]);
    exp_clr = (trig[d] <= n) && (n < trig[d] + l);
    tests++;
    if (bsy !== exp_busy) begin
      fails++;
      $display("FAIL busy_%0d cycle %0d: got %0b, want %0b", d, n, bsy, exp_busy);
    end
    tests++;
    if (clr !== exp_clr) begin
      fails++;
      $display("FAIL clearing_%0d cycle %0d: got %0b, want %0b", d, n, clr, exp_clr);
    end
    while (qsize(d) > 0 && qfront(d).cyc < n) begin
      e = qpop(d);
      tests++;
      fails++;
      $display("FAIL missed_%0d cycle %0d: no write seen, want addr=%0d", d, e.cyc, e.addr);
    end
    if (qsize(d) > 0) begin
      e = qfront(d);
      if (e.cyc == n) begin
        have = 1'b1;
        void'(qpop(d));
      end
    end
    if (ena || have) begin
      tests++;
      if (!(ena && have && addr == e.addr && data == e.data)) begin
        fails++;
        $display("FAIL write_%0d cycle %0d: got ena=%0b addr=%0d data=%h, want ena=%0b addr=%0d data=%h",
                 d, n, ena, addr, data, have, have ? e.addr : 0, have ? e.data : 0);
      end
    end
  endtask

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(negedge clk) begin
    if (ena_a) wr_cnt[0] <= wr_cnt[0] + 1;
    if (ena_b) wr_cnt[1] <= wr_cnt[1] + 1;
    if (busy_a) busy_cnt[0] <= busy_cnt[0] + 1;
    if (busy_b) busy_cnt[1] <= busy_cnt[1] + 1;
  end

  // Monitor: check outputs of edge ecnt, then predict from inputs the next edge samples
  always @(negedge clk) begin
    check_out(0, ecnt, ena_a, int'(addr_a), int'(data_a), busy_a, clearing_a);
    check_out(1, ecnt, ena_b, int'(addr_b), int'(data_b), busy_b, clearing_b);
    while (dq.size() > 0) begin
      dchk_t c;
      string nm;
      c = dq.pop_front();
      nm = dn.pop_front();
      tests++;
      if (c.act != c.expv) begin
        fails++;
        $display("FAIL %s: got %0d, want %0d", nm, c.act, c.expv);
      end
    end
    model_edge(0, ecnt + 1, rst_a, clr_a, tv_a, int'(x_a), int'(y_a));
    model_edge(1, ecnt + 1, rst_b, clr_b, tv_b, int'(x_b), int'(y_b));
  end

  task automatic cyc_n(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic dchk(string nm, int act, int expv);
    dchk_t c;
    c.act = act;
    c.expv = expv;
    dq.push_back(c);
    dn.push_back(nm);
  endtask

  task automatic wait_idle(int d, int bound, string nm);
    int k = 0;
    while (((d == 0) ? busy_a : busy_b) && k < bound) begin
      cyc_n(1);
      k++;
    end
    dchk(nm, int'(k < bound), 1);
    cyc_n(2);
  endtask

  initial begin
    int w0;
    int b0;
    rst_a = 1'b1; clr_a = 1'b0; tv_a = 1'b0; x_a = 9'd0; y_a = 9'd0;
    rst_b = 1'b0; clr_b = 1'b0; tv_b = 1'b0; x_b = 9'd0; y_b = 9'd0;

    // Power-on clear, with a touch and clear request arriving mid-clear
    cyc_n(2);
    rst_a = 1'b0;
    w0 = wr_cnt[0];
    cyc_n(1000);
    tv_a = 1'b1; x_a = 9'd10; y_a = 9'd20; clr_a = 1'b1;
    cyc_n(200);
    tv_a = 1'b0; clr_a = 1'b0;
    wait_idle(0, 80000, "clear_done_a");
    dchk("clear_writes_a", wr_cnt[0] - w0, 76800);

    // Basic paint at (10,20)
    w0 = wr_cnt[0]; b0 = busy_cnt[0];
    tv_a = 1'b1; x_a = 9'd10; y_a = 9'd20;
    cyc_n(1);
    tv_a = 1'b0;
    cyc_n(8);
    dchk("paint_writes", wr_cnt[0] - w0, 4);
    dchk("paint_busy", busy_cnt[0] - b0, 4);

    // Bottom-right corner clips three of four slots
    w0 = wr_cnt[0]; b0 = busy_cnt[0];
    tv_a = 1'b1; x_a = 9'd239; y_a = 9'd319;
    cyc_n(1);
    tv_a = 1'b0;
    cyc_n(8);
    dchk("corner_writes", wr_cnt[0] - w0, 1);
    dchk("corner_busy", busy_cnt[0] - b0, 4);

    // Out-of-range touches are dropped
    w0 = wr_cnt[0]; b0 = busy_cnt[0];
    tv_a = 1'b1; x_a = 9'd240; y_a = 9'd5;
    cyc_n(1);
    tv_a = 1'b0;
    cyc_n(4);
    tv_a = 1'b1; x_a = 9'd5; y_a = 9'd320;
    cyc_n(1);
    tv_a = 1'b0;
    cyc_n(4);
    dchk("oor_writes", wr_cnt[0] - w0, 0);
    dchk("oor_busy", busy_cnt[0] - b0, 0);

    // Held touch repaints continuously
    tv_a = 1'b1; x_a = 9'd3; y_a = 9'd3;
    cyc_n(12);
    tv_a = 1'b0;
    cyc_n(8);

    // Small instance: reset clear
    rst_b = 1'b1;
    cyc_n(2);
    rst_b = 1'b0;
    cyc_n(2);
    wait_idle(1, 200, "clear_done_b");

    // Abort on the third paint edge of a 3x3 brush at (0,0)
    w0 = wr_cnt[1];
    tv_b = 1'b1; x_b = 9'd0; y_b = 9'd0;
    cyc_n(1);
    tv_b = 1'b0;
    cyc_n(2);
    clr_b = 1'b1;
    cyc_n(1);
    clr_b = 1'b0;
    cyc_n(2);
    wait_idle(1, 200, "abort_done");
    dchk("abort_writes", wr_cnt[1] - w0, 2 + LB);

    // Clear wins over a simultaneous touch
    w0 = wr_cnt[1];
    clr_b = 1'b1; tv_b = 1'b1; x_b = 9'd5; y_b = 9'd5;
    cyc_n(1);
    clr_b = 1'b0; tv_b = 1'b0;
    cyc_n(2);
    wait_idle(1, 200, "priority_done");
    dchk("priority_writes", wr_cnt[1] - w0, LB);

    // Reset in the middle of a clear restarts it from address 0
    clr_b = 1'b1;
    cyc_n(1);
    clr_b = 1'b0;
    cyc_n(20);
    rst_b = 1'b1;
    cyc_n(1);
    rst_b = 1'b0;
    cyc_n(2);
    wait_idle(1, 200, "restart_done");

    // Random traffic including near-edge and out-of-range coordinates
    for (int k = 0; k < 1500; k++) begin
      rst_b = (($urandom % 200) == 0);
      clr_b = (($urandom % 40) == 0);
      tv_b  = (($urandom % 3) != 0);
      x_b   = 9'($urandom % 12);
      y_b   = 9'($urandom % 9);
      cyc_n(1);
    end
    rst_b = 1'b0; clr_b = 1'b0; tv_b = 1'b0;
    cyc_n(80);
    dchk("queue_a_empty", qa.size(), 0);
    dchk("queue_b_empty", qb.size(), 0);
    cyc_n(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Owns the single write port of the VRAM block_ram (16-bit RGB565, DISPLAY_WIDTH x DISPLAY_HEIGHT words, row-major).
- Shares that port between two requesters:
  - a clear engine, run after reset and on request;
  - a touch painter, which stamps a BRUSH_SIZE x BRUSH_SIZE square at each valid touch point.
- Sits between the ft6206 touch controller outputs and the VRAM in the etch-a-sketch top level. The display controller keeps the read port.

Parameters:
- DISPLAY_WIDTH, 240, pixels per row (x range).
- DISPLAY_HEIGHT, 320, rows (y range).
- VRAM_L, DISPLAY_WIDTH*DISPLAY_HEIGHT, VRAM depth in words.
- BRUSH_SIZE, 3, side of the painted square in pixels (>=1).
- CLEAR_COLOR, 16'h0000, data written by the clear engine.
- PAINT_COLOR, 16'hFFFF, data written by the painter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- clear_req  input  1  level or pulse; requests a full VRAM clear.
- touch_valid  input  1  touch point present this cycle.
- touch_x  input  9  touch x coordinate.
- touch_y  input  9  touch y coordinate.
- vram_wr_ena  output  1  VRAM write enable (registered).
- vram_wr_addr  output  $clog2(VRAM_L)  VRAM write address (registered).
- vram_wr_data  output  16  VRAM write data (registered).
- busy  output  1  high whenever state != S_IDLE (combinational from state).
- clearing  output  1  high in S_CLEARING.

Behaviour:
- States: S_CLEARING, S_IDLE, S_PAINT.
- Reset (rst high at posedge):
  - state = S_CLEARING, clear counter = 0, paint counter = 0.
  - vram_wr_ena = 0, vram_wr_addr = 0, vram_wr_data = 0.
  - busy = 1, clearing = 1.
- S_CLEARING:
  - Each posedge registers wr_ena = 1, addr = counter, data = CLEAR_COLOR, then increments the counter.
  - Writes are strictly ascending, one per cycle, no gaps: VRAM_L writes, addresses 0..VRAM_L-1.
  - The edge that registers address VRAM_L-1 moves the state to S_IDLE.
  - The next edge registers wr_ena = 0.
  - clear_req is ignored while in S_CLEARING; no restart.
- S_IDLE:
  - Each edge registers wr_ena = 0.
  - Priority at an edge: clear_req first, then touch.
  - If clear_req = 1: go to S_CLEARING with counter = 0.
  - Else if touch_valid = 1 and touch_x < DISPLAY_WIDTH and touch_y < DISPLAY_HEIGHT:
    - latch x0 = touch_x, y0 = touch_y;
    - paint counter k = 0; go to S_PAINT.
  - Out-of-range touches are dropped silently.
- S_PAINT:
  - There are BRUSH_SIZE^2 write slots, one per edge. Slot k maps to pixel (x0 + k mod BRUSH_SIZE, y0 + k div BRUSH_SIZE), with x varying fastest. Use separate i/j counters, not a divider.
  - Pixel inside the display: register wr_ena = 1, addr = y*DISPLAY_WIDTH + x, data = PAINT_COLOR.
  - Pixel outside the display (x >= WIDTH or y >= HEIGHT): register wr_ena = 0; the slot is still consumed. There is no wrap to the next row.
  - The edge registering the last slot returns to S_IDLE.
  - touch_valid is ignored in S_PAINT; there is no queueing. The painter re-samples touch in S_IDLE, so a held touch repaints continuously.
  - clear_req = 1 at any S_PAINT edge aborts the paint: that edge registers wr_ena = 0 and moves to S_CLEARING with counter = 0.
- Latency:
  - Touch sampled in S_IDLE at edge N → first write registered at edge N+1, visible during cycle N+1..N+2.
  - Square complete after BRUSH_SIZE^2 edges.
  - Earliest next acceptance is the edge after returning to S_IDLE, so there is a one-cycle gap between squares.
- Arithmetic:
  - Address computation is done at full $clog2(VRAM_L) width.
  - x + i and y + j are computed at 10 bits so the bound check cannot overflow.
  - The multiply is by a constant.
- Reset mid-operation: any state → S_CLEARING from address 0; any in-flight paint is lost.
- The address never exceeds VRAM_L-1 while wr_ena = 1.

Test Plan:
- Power-on clear: pulse rst 2 cycles, release. Required:
  - wr_ena goes high the cycle after the first non-reset edge;
  - exactly 76800 consecutive writes, addr 0..76799, data 16'h0000;
  - busy falls after the last write;
  - clearing = 1 throughout.
- Basic paint: BRUSH_SIZE = 2, in S_IDLE, touch (10,20) valid for 1 cycle. Required:
  - writes to addrs 4810, 4811, 5050, 5051 in that order, data 16'hFFFF, on 4 consecutive cycles;
  - the first write appears 1 cycle after acceptance.
- Corner clip: BRUSH_SIZE = 2, touch (239,319). Required:
  - exactly one write, addr 76799;
  - 3 slots with wr_ena = 0;
  - busy high for 4 cycles.
- Ignored inputs:
  - touch_valid asserted during S_CLEARING → no paint writes; the clear sequence is unchanged;
  - touch (240,5) or (5,320) in S_IDLE → no writes and busy stays 0.
- Abort: BRUSH_SIZE = 3, touch (0,0), assert clear_req on the 3rd paint edge. Required:
  - 2 paint writes (addr 0 and 1);
  - one cycle with wr_ena = 0;
  - full clear from addr 0.
- Priority: clear_req and touch_valid (5,5) asserted on the same S_IDLE edge → clear runs and the touch is dropped. A mid-clear rst restarts the clear at addr 0.
